// File: rtl/pcie_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// pcie_tx_arbiter_if
//   Bundles the request side (NREQ AXI-stream sources), the single slot-facing
//   s_axis_tx channel and the slot's config-TLP handshake.
//
//   Modports:
//     slave  : the arbiter's view. It receives the requester streams and
//              tx_buf_av/tx_cfg_req, and drives req_tready, s_axis_tx_* and
//              tx_cfg_gnt.
//     master : the surrounding environment (requesters plus slot), i.e. the
//              mirror image of slave.
//
//   Signals:
//     req_tdata   NREQ*64  per-requester data, port i at [64i+63:64i]
//     req_tkeep   NREQ*8   per-requester byte enables
//     req_tlast   NREQ     per-requester end of TLP
//     req_tvalid  NREQ     per-requester valid
//     req_tready  NREQ     per-requester ready
//     s_axis_tx_* 64/8/1/1 stream to the slot, tready back from the slot
//     tx_buf_av   6        free transmit buffers reported by the slot
//     tx_cfg_req  1        core requests the channel for a config TLP
//     tx_cfg_gnt  1        grant to the core
// ---------------------------------------------------------------------------
interface pcie_tx_arbiter_if #(
    parameter int NREQ = 4
) ();
    logic [NREQ*64-1:0] req_tdata;
    logic [NREQ*8-1:0]  req_tkeep;
    logic [NREQ-1:0]    req_tlast;
    logic [NREQ-1:0]    req_tvalid;
    logic [NREQ-1:0]    req_tready;

    logic [63:0]        s_axis_tx_tdata;
    logic [7:0]         s_axis_tx_tkeep;
    logic               s_axis_tx_tlast;
    logic               s_axis_tx_tvalid;
    logic               s_axis_tx_tready;

    logic [5:0]         tx_buf_av;
    logic               tx_cfg_req;
    logic               tx_cfg_gnt;

    modport slave (
        input  req_tdata, req_tkeep, req_tlast, req_tvalid,
        output req_tready,
        output s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tlast, s_axis_tx_tvalid,
        input  s_axis_tx_tready,
        input  tx_buf_av, tx_cfg_req,
        output tx_cfg_gnt
    );

    modport master (
        output req_tdata, req_tkeep, req_tlast, req_tvalid,
        input  req_tready,
        input  s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tlast, s_axis_tx_tvalid,
        output s_axis_tx_tready,
        output tx_buf_av, tx_cfg_req,
        input  tx_cfg_gnt
    );
endinterface

// File: rtl/pcie_tx_arbiter.sv
// ---------------------------------------------------------------------------
// pcie_tx_arbiter
//   Shares the slot's single s_axis_tx channel among NREQ TLP generators.
//   Round-robin arbitration happens only between TLPs; a granted port is
//   passed straight through (combinationally) until its tlast beat is
//   accepted. The block also owns tx_cfg_req/tx_cfg_gnt so the core only
//   inserts config TLPs between user packets.
//
//   Ports:
//     user_clk      transmit clock from the slot
//     user_reset_n  synchronous active-low reset
//     bus           pcie_tx_arbiter_if.slave (requesters, s_axis_tx, cfg
//                   handshake, tx_buf_av)
//     active_port   index of the current or last granted requester
//     pkt_count     completed user TLPs, wraps 0xFFFF -> 0
//
//   SELW must equal clog2(NREQ); MIN_BUF is the tx_buf_av needed to start a
//   user packet (not re-checked mid-packet).
// ---------------------------------------------------------------------------
module pcie_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int MIN_BUF = 1,
    parameter int SELW    = 2
) (
    input  logic              user_clk,
    input  logic              user_reset_n,
    pcie_tx_arbiter_if.slave  bus,
    output logic [SELW-1:0]   active_port,
    output logic [15:0]       pkt_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PKT  = 2'd1,
        CFG  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [SELW-1:0] sel;
    logic [SELW-1:0] last_winner;

    logic [SELW-1:0] grant_idx;
    logic            grant_found;
    logic [SELW-1:0] cand;
    logic            pkt_live;
    logic            beat_end;

    // The pass-through is also cut while reset is held, so no beat leaks
    // to the slot during the reset cycle of an abandoned packet.
    assign pkt_live = (state == PKT) && user_reset_n;
    assign beat_end = pkt_live && bus.req_tvalid[sel] && bus.s_axis_tx_tready
                      && bus.req_tlast[sel];

    assign active_port = sel;

    // Round-robin pick: first valid port after last_winner, wrapping.
    // NOTE: combinational blocks use blocking '=' and assign a default to
    // every variable first, so no path can leave one unassigned (a latch).
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = SELW'((int'(last_winner) + k) % NREQ);
            if (!grant_found && bus.req_tvalid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // State register. An unused encoding is caught by the next-state
    // default and returns to IDLE on the following edge.
    // NOTE: sequential state is only ever written with non-blocking '<='.
    always_ff @(posedge user_clk) begin
        if (!user_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. Config requests win over starting a user packet,
    // but never interrupt one already in flight.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.tx_cfg_req) begin
                    state_nxt = CFG;
                end else if (grant_found && int'(bus.tx_buf_av) >= MIN_BUF) begin
                    state_nxt = PKT;
                end
            end
            PKT: begin
                if (beat_end) begin
                    state_nxt = IDLE;
                end
            end
            CFG: begin
                if (!bus.tx_cfg_req) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: pass-through of port sel in PKT, everything idle
    // otherwise. tx_cfg_gnt decodes the state register, so it is glitch-free
    // and drops on the edge that samples tx_cfg_req low.
    always_comb begin
        bus.s_axis_tx_tdata  = '0;
        bus.s_axis_tx_tkeep  = '0;
        bus.s_axis_tx_tlast  = 1'b0;
        bus.s_axis_tx_tvalid = 1'b0;
        bus.req_tready       = '0;
        bus.tx_cfg_gnt       = (state == CFG);
        if (pkt_live) begin
            bus.s_axis_tx_tdata  = bus.req_tdata[{sel, 6'd0} +: 64];
            bus.s_axis_tx_tkeep  = bus.req_tkeep[{sel, 3'd0} +: 8];
            bus.s_axis_tx_tlast  = bus.req_tlast[sel];
            bus.s_axis_tx_tvalid = bus.req_tvalid[sel];
            bus.req_tready[sel]  = bus.s_axis_tx_tready;
        end
    end

    // Grant bookkeeping. last_winner only moves when a user TLP completes,
    // so config grants and reset-abandoned packets leave priority unchanged.
    always_ff @(posedge user_clk) begin
        if (!user_reset_n) begin
            sel         <= '0;
            last_winner <= SELW'(NREQ - 1);
            pkt_count   <= '0;
        end else begin
            if (state == IDLE && state_nxt == PKT) begin
                sel <= grant_idx;
            end
            if (beat_end) begin
                last_winner <= sel;
                pkt_count   <= pkt_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pcie_tx_arbiter
//   Directed scenarios followed by a randomized phase. Each requester is a
//   queue of beats; a transaction-level reference model (owner port, config
//   ownership, round-robin pointer, packet count) predicts every cycle's
//   outputs.
// ---------------------------------------------------------------------------
module tb_pcie_tx_arbiter;
    localparam int NREQ    = 4;
    localparam int MIN_BUF = 1;
    localparam int SELW    = 2;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    logic            user_clk = 1'b0;
    logic            user_reset_n;
    logic [SELW-1:0] active_port;
    logic [15:0]     pkt_count;

    pcie_tx_arbiter_if #(.NREQ(NREQ)) bus ();

    pcie_tx_arbiter #(
        .NREQ    (NREQ),
        .MIN_BUF (MIN_BUF),
        .SELW    (SELW)
    ) dut (
        .user_clk     (user_clk),
        .user_reset_n (user_reset_n),
        .bus          (bus),
        .active_port  (active_port),
        .pkt_count    (pkt_count)
    );

    always #5 user_clk = ~user_clk;

    int checks = 0;
    int errors = 0;

    beat_t      src_q [NREQ][$];
    logic       s_tready_v;
    logic [5:0] buf_av_v;
    logic       cfg_req_v;

    // Reference model: who owns the channel (-1 = nobody), config ownership,
    // round-robin pointer, last granted port, completed packet count.
    int m_busy;
    int m_lw;
    int m_act;
    int m_cnt;
    bit m_cfg;

    // Ports observed on the DUT at each accepted tlast beat.
    int done_log [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s timed out", tag);
    endtask

    task automatic model_reset();
        m_busy = -1;
        m_lw   = NREQ - 1;
        m_act  = 0;
        m_cnt  = 0;
        m_cfg  = 1'b0;
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (src_q[i].size() > 0) p = 1'b1;
        end
        return p;
    endfunction

    task automatic push_pkt(input int port, input int len);
        beat_t b;
        for (int j = 0; j < len; j++) begin
            b.data = {$urandom, $urandom};
            b.keep = (j == len - 1) ? 8'($urandom_range(1, 255)) : 8'hFF;
            b.last = (j == len - 1);
            src_q[port].push_back(b);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (src_q[i].size() > 0) begin
                bus.req_tdata[64*i +: 64] = src_q[i][0].data;
                bus.req_tkeep[8*i +: 8]   = src_q[i][0].keep;
                bus.req_tlast[i]          = src_q[i][0].last;
                bus.req_tvalid[i]         = 1'b1;
            end else begin
                bus.req_tdata[64*i +: 64] = '0;
                bus.req_tkeep[8*i +: 8]   = '0;
                bus.req_tlast[i]          = 1'b0;
                bus.req_tvalid[i]         = 1'b0;
            end
        end
        bus.s_axis_tx_tready = s_tready_v;
        bus.tx_buf_av        = buf_av_v;
        bus.tx_cfg_req       = cfg_req_v;
    endtask

    task automatic observe();
        logic [NREQ-1:0] exp_rdy;
        bit live;
        exp_rdy = '0;
        live    = 1'b0;
        if (user_reset_n && m_busy >= 0) begin
            live = (src_q[m_busy].size() > 0);
            exp_rdy[m_busy] = s_tready_v;
        end
        chk("s_tvalid", bus.s_axis_tx_tvalid, live);
        if (live) begin
            chk("s_tdata", bus.s_axis_tx_tdata, src_q[m_busy][0].data);
            chk("s_tkeep", bus.s_axis_tx_tkeep, src_q[m_busy][0].keep);
            chk("s_tlast", bus.s_axis_tx_tlast, src_q[m_busy][0].last);
        end
        chk("req_tready", bus.req_tready, exp_rdy);
        if (user_reset_n) begin
            chk("tx_cfg_gnt", bus.tx_cfg_gnt, m_cfg);
            chk("pkt_count", pkt_count, m_cnt);
            chk("active_port", active_port, m_act);
        end
    endtask

    // Advance the model and the sources with the values present before the edge.
    task automatic update();
        logic [NREQ-1:0] fired;
        int p;
        fired = bus.req_tvalid & bus.req_tready;
        if (bus.s_axis_tx_tvalid && bus.s_axis_tx_tready && bus.s_axis_tx_tlast)
            done_log.push_back(int'(active_port));
        if (!user_reset_n) begin
            model_reset();
            for (int i = 0; i < NREQ; i++) src_q[i].delete();
            return;
        end
        if (m_busy >= 0) begin
            if (src_q[m_busy].size() > 0 && s_tready_v && src_q[m_busy][0].last) begin
                m_lw   = m_busy;
                m_cnt  = (m_cnt + 1) % 65536;
                m_busy = -1;
            end
        end else if (m_cfg) begin
            if (!cfg_req_v) m_cfg = 1'b0;
        end else if (cfg_req_v) begin
            m_cfg = 1'b1;
        end else if (int'(buf_av_v) >= MIN_BUF) begin
            for (int k = 1; k <= NREQ; k++) begin
                p = (m_lw + k) % NREQ;
                if (m_busy < 0 && src_q[p].size() > 0) begin
                    m_busy = p;
                    m_act  = p;
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (fired[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        end
    endtask

    task automatic step();
        drive();
        #1;
        observe();
        update();
        @(posedge user_clk);
        @(negedge user_clk);
    endtask

    task automatic run_until_idle(input int bound, input string tag);
        int n = 0;
        while ((m_busy >= 0 || pending()) && n < bound) begin
            step();
            n++;
        end
        if (n >= bound) timeout(tag);
    endtask

    task automatic wait_busy(input int port, input int bound, input string tag);
        int n = 0;
        while (m_busy != port && n < bound) begin
            step();
            n++;
        end
        if (n >= bound) timeout(tag);
    endtask

    task automatic apply_reset();
        user_reset_n = 1'b0;
        step();
        user_reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int pat [6] = '{1, 0, 0, 1, 1, 1};
        int n;

        user_reset_n = 1'b0;
        s_tready_v   = 1'b1;
        buf_av_v     = 6'd10;
        cfg_req_v    = 1'b0;
        model_reset();
        drive();
        @(negedge user_clk);
        repeat (3) step();
        user_reset_n = 1'b1;
        chk("reset_pkt_count", pkt_count, 16'd0);
        chk("reset_active_port", active_port, 0);
        chk("reset_cfg_gnt", bus.tx_cfg_gnt, 1'b0);

        // Single 3-beat TLP from port 2.
        done_log.delete();
        push_pkt(2, 3);
        step();
        drive();
        #1;
        chk("t1_first_beat", bus.s_axis_tx_tvalid, 1'b1);
        run_until_idle(20, "t1_drain");
        chk("t1_active_port", active_port, 2);
        chk("t1_pkt_count", pkt_count, 16'd1);
        chk("t1_log_size", done_log.size(), 1);

        // All ports busy with 2-beat TLPs: grant order 0,1,2,3,0.
        apply_reset();
        done_log.delete();
        for (int i = 0; i < NREQ; i++) begin
            push_pkt(i, 2);
            push_pkt(i, 2);
        end
        n = 0;
        while (m_cnt < 5 && n < 60) begin
            step();
            n++;
        end
        if (n >= 60) timeout("t2_five_pkts");
        chk("t2_pkt_count", pkt_count, 16'd5);
        chk("t2_log_size", done_log.size(), 5);
        if (done_log.size() >= 5) begin
            chk("t2_order0", done_log[0], 0);
            chk("t2_order1", done_log[1], 1);
            chk("t2_order2", done_log[2], 2);
            chk("t2_order3", done_log[3], 3);
            chk("t2_order4", done_log[4], 0);
        end
        run_until_idle(60, "t2_drain");

        // Config request raised on beat 1 of a 4-beat TLP from port 1.
        done_log.delete();
        push_pkt(1, 4);
        wait_busy(1, 20, "t3_grant1");
        cfg_req_v = 1'b1;
        n = 0;
        while (m_busy >= 0 && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) timeout("t3_pkt_end");
        chk("t3_gnt_low_after_tlast", bus.tx_cfg_gnt, 1'b0);
        push_pkt(0, 2);
        push_pkt(2, 2);
        step();
        chk("t3_gnt_rise", bus.tx_cfg_gnt, 1'b1);
        repeat (3) step();
        cfg_req_v = 1'b0;
        step();
        chk("t3_gnt_fall", bus.tx_cfg_gnt, 1'b0);
        run_until_idle(40, "t3_drain");
        chk("t3_log_size", done_log.size(), 3);
        if (done_log.size() >= 3) begin
            chk("t3_first", done_log[0], 1);
            chk("t3_next_port2", done_log[1], 2);
        end

        // No buffer space: the request waits until tx_buf_av reaches MIN_BUF.
        buf_av_v = 6'd0;
        push_pkt(0, 2);
        repeat (4) step();
        chk("t4_held", bus.s_axis_tx_tvalid, 1'b0);
        buf_av_v = 6'd1;
        step();
        drive();
        #1;
        chk("t4_start", bus.s_axis_tx_tvalid, 1'b1);
        run_until_idle(20, "t4_drain");
        buf_av_v = 6'd10;

        // Backpressure pattern during a 3-beat TLP from port 3.
        push_pkt(3, 3);
        wait_busy(3, 20, "t5_grant3");
        for (int i = 0; i < 6; i++) begin
            s_tready_v = pat[i][0];
            step();
        end
        s_tready_v = 1'b1;
        run_until_idle(20, "t5_drain");
        chk("t5_active_port", active_port, 3);

        // Reset on beat 2 of a TLP from port 3; port 0 wins afterwards.
        push_pkt(3, 4);
        wait_busy(3, 20, "t6_grant3");
        step();
        user_reset_n = 1'b0;
        step();
        user_reset_n = 1'b1;
        chk("t6_tvalid", bus.s_axis_tx_tvalid, 1'b0);
        chk("t6_pkt_count", pkt_count, 16'd0);
        done_log.delete();
        push_pkt(0, 2);
        push_pkt(3, 2);
        run_until_idle(30, "t6_drain");
        chk("t6_log_size", done_log.size(), 2);
        if (done_log.size() >= 2) begin
            chk("t6_port0_first", done_log[0], 0);
        end

        // Randomized traffic, backpressure, buffer starvation and config requests.
        for (int c = 0; c < 600; c++) begin
            int port = int'($urandom_range(0, NREQ - 1));
            if ($urandom_range(0, 3) == 0 && src_q[port].size() < 8)
                push_pkt(port, int'($urandom_range(1, 5)));
            s_tready_v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) buf_av_v = 6'($urandom_range(0, 3));
            else if ($urandom_range(0, 7) == 0) buf_av_v = 6'd10;
            if (cfg_req_v) cfg_req_v = ($urandom_range(0, 3) != 0);
            else cfg_req_v = ($urandom_range(0, 29) == 0);
            step();
        end
        cfg_req_v  = 1'b0;
        s_tready_v = 1'b1;
        buf_av_v   = 6'd10;
        run_until_idle(800, "rand_drain");
        step();
        chk("rand_final_count", pkt_count, m_cnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
